// File: rtl/ultrasonic_scheduler.sv
// ============================================================================
// Module      : ultrasonic_scheduler
// Description : Periodic trigger/echo sequencer for an HC-SR04 style ranger.
//               Optional macro ULTRASONIC_NEAR_FILTER_EN adds a run-length
//               filter on the proximity flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ultrasonic_scheduler #(
    parameter int TRIG_CYCLES      = 500,
    parameter int PERIOD_CYCLES    = 3000000,
    parameter int ECHO_WAIT_CYCLES = 1500000,
    parameter int ECHO_MAX_CYCLES  = 1250000,
    parameter int NEAR_MIN         = 2900,
    parameter int NEAR_MAX         = 14500
`ifdef ULTRASONIC_NEAR_FILTER_EN
    ,
    parameter int FILT_N           = 3
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        echo,
    output logic        trigger,
    output logic [31:0] echo_duration,
    output logic        sample_valid,
    output logic        timeout,
    output logic        busy,
    output logic        near
);

    localparam logic [31:0] c_trig_last   = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] c_wait_last   = 32'(ECHO_WAIT_CYCLES - 1);
    localparam logic [31:0] c_echo_max    = 32'(ECHO_MAX_CYCLES);
    localparam logic [31:0] c_period_last = 32'(PERIOD_CYCLES - 1);
    localparam logic [31:0] c_near_min    = 32'(NEAR_MIN);
    localparam logic [31:0] c_near_max    = 32'(NEAR_MAX);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [31:0] trig_cnt_q, trig_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] meas_cnt_q, meas_cnt_d;
    logic [31:0] dur_q, dur_d;
    logic        trig_q, trig_d;
    logic        valid_q, valid_d;
    logic        tmo_q, tmo_d;
    logic        near_q, near_d;
    logic        sync1_q, echo_s_q, echo_d_q;
    logic        w_rise, w_fall, w_eval, w_in_range;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            echo_s_q <= 1'b0;
            echo_d_q <= 1'b0;
        end else begin
            sync1_q  <= echo;
            echo_s_q <= sync1_q;
            echo_d_q <= echo_s_q;
        end
    end

    assign w_rise = echo_s_q & ~echo_d_q;
    assign w_fall = ~echo_s_q & echo_d_q;

    always_comb begin
        state_d    = state_q;
        period_d   = (state_q != ST_IDLE) ? period_q + 32'd1 : period_q;
        trig_cnt_d = trig_cnt_q;
        wait_cnt_d = wait_cnt_q;
        meas_cnt_d = meas_cnt_q;
        dur_d      = dur_q;
        trig_d     = 1'b0;
        valid_d    = 1'b0;
        tmo_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_TRIG;
                    trig_cnt_d = 32'd0;
                    period_d   = 32'd0;
                    trig_d     = 1'b1;
                end
            end
            ST_TRIG: begin
                if (trig_cnt_q == c_trig_last) begin
                    state_d    = ST_WAIT_RISE;
                    wait_cnt_d = 32'd0;
                end else begin
                    trig_cnt_d = trig_cnt_q + 32'd1;
                    trig_d     = 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                if (w_rise) begin
                    state_d    = ST_MEASURE;
                    meas_cnt_d = 32'd1;
                end else if (wait_cnt_q == c_wait_last) begin
                    state_d = ST_HOLDOFF;
                    tmo_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            ST_MEASURE: begin
                // A fall on the cycle the count saturates still yields a valid sample.
                if (w_fall) begin
                    state_d = ST_HOLDOFF;
                    dur_d   = meas_cnt_q;
                    valid_d = 1'b1;
                end else if (meas_cnt_q == c_echo_max) begin
                    state_d = ST_HOLDOFF;
                    dur_d   = c_echo_max;
                    tmo_d   = 1'b1;
                end else if (echo_s_q) begin
                    meas_cnt_d = meas_cnt_q + 32'd1;
                end
            end
            ST_HOLDOFF: begin
                if (period_q == c_period_last) begin
                    if (enable) begin
                        state_d    = ST_TRIG;
                        trig_cnt_d = 32'd0;
                        period_d   = 32'd0;
                        trig_d     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign w_eval     = valid_d | tmo_d;
    assign w_in_range = valid_d && (dur_d > c_near_min) && (dur_d < c_near_max);

`ifdef ULTRASONIC_NEAR_FILTER_EN
    localparam logic [2:0] c_filt_last = 3'(FILT_N - 1);
    logic [2:0] run_q, run_d;

    always_comb begin
        near_d = near_q;
        run_d  = run_q;
        if (w_eval) begin
            if (w_in_range == near_q) begin
                run_d = 3'd0;
            end else if (run_q == c_filt_last) begin
                near_d = w_in_range;
                run_d  = 3'd0;
            end else begin
                run_d = run_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) run_q <= 3'd0;
        else        run_q <= run_d;
    end
`else
    always_comb begin
        near_d = near_q;
        if (w_eval) near_d = w_in_range;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            period_q   <= 32'd0;
            trig_cnt_q <= 32'd0;
            wait_cnt_q <= 32'd0;
            meas_cnt_q <= 32'd0;
            dur_q      <= 32'd0;
            trig_q     <= 1'b0;
            valid_q    <= 1'b0;
            tmo_q      <= 1'b0;
            near_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            trig_cnt_q <= trig_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            meas_cnt_q <= meas_cnt_d;
            dur_q      <= dur_d;
            trig_q     <= trig_d;
            valid_q    <= valid_d;
            tmo_q      <= tmo_d;
            near_q     <= near_d;
        end
    end

    assign trigger       = trig_q;
    assign echo_duration = dur_q;
    assign sample_valid  = valid_q;
    assign timeout       = tmo_q;
    assign busy          = (state_q != ST_IDLE);
    assign near          = near_q;

endmodule

`default_nettype wire
